mem_arbiter: RTL

Two-master arbiter that shares one synchronous-read, byte-masked data RAM between the multicycle core (master 0) and a second requester such as a program loader or debug/DMA port (master 1). Each master uses a req/gnt/rvalid handshake. The block registers the winning request, drives the single RAM port for exactly one cycle, and returns read data one cycle later. Arbitration is round-robin or fixed priority.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arbiter_rr_pick.sv | 23 ++
 rtl/mem_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master data RAM arbiter.
// State encoding, master ids and the captured request bundle.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int REQ_AW = 32;
  localparam int REQ_DW = 32;

  typedef struct packed {
    logic [REQ_AW-1:0] addr;
    logic [REQ_DW-1:0] wdata;
    logic [3:0]        wmask;
    logic              we;
  } req_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational 2-way picker: round-robin on last winner or
// fixed priority to master 0.
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = M0;
    unique case (1'b1)
      (req == 2'b10): winner = M1;
      (req == 2'b11): winner = rr ? ~last : M0;
      default:        winner = M0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read byte-masked RAM between two masters.
// IDLE captures the winner, ACCESS drives the port, RESP returns data.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int RR = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [3:0]    m0_wmask,
  input  logic          m0_we,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [3:0]    m1_wmask,
  input  logic          m1_we,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wmask,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic RR_EN = (RR != 0);

  state_t  state_q, state_d;
  logic    last_q;
  logic    id_q;
  req_t    cap_q;
  req_t    sel;
  logic    win;
  logic    pick_valid;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic    in_access, in_resp;

  rr_pick u_pick (
    .req    ({m1_req, m0_req}),
    .last   (last_q),
    .rr     (RR_EN),
    .winner (win),
    .valid  (pick_valid)
  );

  always_comb begin
    sel = '0;
    if (win == M1) begin
      sel.addr  = REQ_AW'(m1_addr);
      sel.wdata = REQ_DW'(m1_wdata);
      sel.wmask = m1_wmask;
      sel.we    = m1_we;
    end else begin
      sel.addr  = REQ_AW'(m0_addr);
      sel.wdata = REQ_DW'(m0_wdata);
      sel.wmask = m0_wmask;
      sel.we    = m0_we;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_valid) state_d = ACCESS;
      ACCESS:  state_d = cap_q.we ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      last_q   <= M1;
      id_q     <= M0;
      cap_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_valid) begin
        cap_q  <= sel;
        id_q   <= win;
        last_q <= win;
      end
      if (m0_rvalid) rdata0_q <= mem_rdata;
      if (m1_rvalid) rdata1_q <= mem_rdata;
    end
  end

  // Handshake pulses are masked while reset is low so an
  // aborted transfer never reports gnt or rvalid.
  assign in_access = reset && (state_q == ACCESS);
  assign in_resp   = reset && (state_q == RESP);

  assign m0_gnt    = in_access && (id_q == M0);
  assign m1_gnt    = in_access && (id_q == M1);
  assign m0_rvalid = in_resp && (id_q == M0);
  assign m1_rvalid = in_resp && (id_q == M1);
  assign m0_rdata  = m0_rvalid ? mem_rdata : rdata0_q;
  assign m1_rdata  = m1_rvalid ? mem_rdata : rdata1_q;

  assign mem_addr  = cap_q.addr[AW-1:0];
  assign mem_wdata = cap_q.wdata[DW-1:0];
  assign mem_we    = in_access && cap_q.we;
  assign mem_wmask = mem_we ? cap_q.wmask : 4'b0000;
  assign busy      = (state_q != IDLE);

endmodule
